// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A 32-bit packed BCD word is captured on `load` and the eight digits are
// scanned round-robin, each digit slot lasting REFRESH_DIV clock cycles. The
// first cycle of every slot is blanked (all anodes off) so the previous
// digit's cathode pattern never ghosts onto the next anode.
//
// All outputs are registered: the pins reflect the (cnt, idx, disp) state
// one clock after that state was present.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a digit k>=1 whose value and every higher digit are zero is
//   suppressed (anode off, segments off) for its whole slot. Digit 0 is always
//   shown. Invalid BCD digits (10..15) count as nonzero.
//   When undefined, all eight digits are always driven.
//
// Reset is asynchronous and active-high; it forces the pins dark at once.

module bcd_display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] BCD_number,
  input  logic        load,
  output logic [7:0]  anode,
  output logic [6:0]  seg
);

  // Counter width is ceil(log2(REFRESH_DIV)), never narrower than one bit.
  localparam int CNT_W = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [31:0]      disp_q,  disp_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       seg_q,   seg_d;

  // Digit currently addressed by the scan index.
  logic [3:0] cur_digit;
  // High when the addressed digit must be kept dark (leading-zero blanking).
  logic       suppress;

  // Seven-segment decode; anything outside 0..9 shows a lone dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Select the addressed nibble of the latched display value.
  always_comb begin : digit_select
    cur_digit = disp_q[{idx_q, 2'b00} +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k] is high when digits k..7 of disp are all zero.
  logic [7:0] zero_from;

  // Build the "everything from here upward is zero" chain, top digit first.
  always_comb begin : leading_zero_chain
    zero_from    = '0;
    zero_from[7] = (disp_q[31:28] == 4'd0);
    for (int k = 6; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] & (disp_q[4*k +: 4] == 4'd0);
    end
  end

  // Digit 0 is never suppressed so a zero value still shows a single "0".
  always_comb begin : suppress_select
    suppress = (idx_q != 3'd0) && zero_from[idx_q];
  end
`else
  // Without blanking every digit is always driven.
  always_comb begin : suppress_select
    suppress = 1'b0;
  end
`endif

  // Slot counter, scan index and display latch next-state.
  always_comb begin : next_state
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;   // 3-bit index wraps 7 -> 0 on its own
    end
    disp_d = load ? BCD_number : disp_q;
  end

  // Pin values for the next cycle, built from the current (pre-edge) state.
  always_comb begin : output_next
    if ((cnt_q == '0) || suppress) begin
      anode_d = AN_OFF;
    end else begin
      anode_d = ~(8'h01 << idx_q);
    end
    seg_d = suppress ? SEG_OFF : decode_digit(cur_digit);
  end

  // All state and pin registers, cleared asynchronously to a dark display.
  always_ff @(posedge clk or posedge reset) begin : state_regs
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      anode_q <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Testbench for bcd_display_scanner (REFRESH_DIV = 4).
// Reference model: the pins after edge n follow from the position of that
// edge in the scan (cycles since reset release) and the last loaded value.
// Define LEADING_ZERO_BLANK_EN for both files to exercise blanking.

module tb_bcd_display_scanner;

  localparam int RDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] BCD_number;
  logic        load;
  logic [7:0]  anode;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: edges since reset release, and the value the display holds.
  int          pos;
  logic [31:0] disp_m;
  logic [14:0] exp_q[$];   // {anode, seg} expected after the next edge

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                               7'h3F, 7'h3F, 7'h3F, 7'h3F};

  bcd_display_scanner #(.REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .BCD_number (BCD_number),
    .load       (load),
    .anode      (anode),
    .seg        (seg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)", tag, got, exp, $time, pos);
  endtask

  // ---------------- reference model ----------------
  // Expected pins produced by the edge about to happen, then advance the model.
  task automatic model_edge(input logic ld, input logic [31:0] val);
    int slot, digit_i, dig;
    bit sup;
    logic [7:0] a;
    logic [6:0] s;
    slot    = pos % RDIV;
    digit_i = (pos / RDIV) % 8;
    dig     = int'((disp_m >> (4 * digit_i)) & 32'hF);
    sup     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    sup = (digit_i != 0) && ((disp_m >> (4 * digit_i)) == 32'd0);
`endif
    a = (slot == 0 || sup) ? 8'hFF : ~(8'(1) << digit_i);
    s = sup ? 7'h7F : dec_tbl[dig];
    exp_q.push_back({a, s});
    pos++;
    if (ld) disp_m = val;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic ld, input logic [31:0] val);
    logic [14:0] e;
    @(negedge clk);
    load       = ld;
    BCD_number = val;
    model_edge(ld, val);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("anode", 32'(anode), 32'(e[14:7]));
    check("seg",   32'(seg),   32'(e[6:0]));
    check("one_anode", 32'($countones(~anode) <= 1), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  // Async reset at a point away from any edge, checked before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_seg",   32'(seg),   32'h7F);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_anode", 32'(anode), 32'hFF);
    reset  = 1'b0;
    pos    = 0;
    disp_m = 32'd0;
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int top;
    v   = $urandom;
    top = $urandom_range(0, 8);
    if (top < 8) v = v & ((32'd1 << (4 * top)) - 32'd1);
    return v;
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    BCD_number = 32'd0;
    pos        = 0;
    disp_m     = 32'd0;
    #1;
    check("por_anode", 32'(anode), 32'hFF);
    check("por_seg",   32'(seg),   32'h7F);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Release: edge 1 blank, edges 2-4 digit 0 showing "0".
    idle(12);

    // Full scan of 87654321, more than one frame to see the wrap.
    step(1'b1, 32'h87654321);
    idle(40);

    // Load 9 while digit 0 is lit (pre-edge slot position 1 of digit 0).
    while ((pos % (8 * RDIV)) != 1) step(1'b0, $urandom);
    step(1'b1, 32'h00000009);
    idle(3);

    // Invalid BCD digit shows a dash.
    step(1'b1, 32'h0000000F);
    idle(34);

    // Leading-zero case.
    step(1'b1, 32'h00000120);
    idle(34);

    // Zero value.
    step(1'b1, 32'h00000000);
    idle(34);

    // Load coinciding with a digit change.
    while ((pos % RDIV) != RDIV - 1) step(1'b0, $urandom);
    step(1'b1, 32'h00005678);
    idle(RDIV * 9);

    // Randomized traffic with occasional loads.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), rand_bcd());
    end

    // Mid-scan reset with a nonzero display, then restart.
    step(1'b1, 32'h13572468);
    idle(9);
    do_reset();
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
